// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART core.
// UART_PARITY_EN adds the parity state to the encoding.
package uart_pkg;

    // Ticks per data bit and the tick on which the start bit is re-checked.
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned START_MID  = 7;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**W, width B.
// Reads when empty and writes when full are ignored. If both are requested while
// full, both happen. If both are requested while empty, only the write happens.
module uart_fifo #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH    = 1 << W;
    localparam logic [W:0]  FULL_CNT = (W + 1)'(DEPTH);

    logic [B-1:0] mem_q [DEPTH];
    logic [W-1:0] wr_ptr_q;
    logic [W-1:0] rd_ptr_q;
    logic [W:0]   count_q;
    logic         do_wr;
    logic         do_rd;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign do_rd  = rd && !empty;
    assign do_wr  = wr && (!full || do_rd);
    assign r_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**W.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with a runtime baud divisor, RX/TX FIFOs and sticky error flags.
// Optional UART_PARITY_EN: adds one parity bit after the data bits on TX and RX.
// PARITY_ODD selects even (0) or odd (1) parity.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR_BIT = 16,
    parameter int unsigned FIFO_W   = 2
`ifdef UART_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                frame_err,
    output logic                overrun_err,
    output logic                parity_err,
    input  logic                clr_err
);

    // Tick counter must reach SB_TICK-1 (up to 31 for two stop bits).
    localparam int unsigned S_W = 6;
    localparam int unsigned N_W = $clog2(DBIT);

    // ---------------- baud generator ----------------
    logic [DVSR_BIT-1:0] baud_cnt_q;
    logic [DVSR_BIT-1:0] dvsr_q;
    logic                tick;

    assign tick = (baud_cnt_q == dvsr_q);

    // Count 0..dvsr; a new divisor is only picked up when the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            dvsr_q     <= dvsr;
        end else if (tick) begin
            baud_cnt_q <= '0;
            dvsr_q     <= dvsr;
        end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
        end
    end

    // ---------------- rx synchroniser ----------------
    logic [1:0] rx_sync_q;
    logic       rx_in;

    assign rx_in = rx_sync_q[1];

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    // ---------------- receiver ----------------
    uart_state_e     rx_state_q, rx_state_d;
    logic [S_W-1:0]  rx_tick_q, rx_tick_d;
    logic [N_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DBIT-1:0] rx_shift_q, rx_shift_d;
    logic            rx_done;
    logic            rx_frame_bad;
    logic            rx_full;
    logic            rx_push;
`ifdef UART_PARITY_EN
    logic            rx_par_bad;
`endif

    // RX next-state: mid-bit sampling driven by the oversample tick.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tick_d    = rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_done      = 1'b0;
        rx_frame_bad = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad   = 1'b0;
`endif
        unique case (rx_state_q)
            StIdle: begin
                if (!rx_in) begin
                    rx_state_d = StStart;
                    rx_tick_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rx_tick_q == S_W'(START_MID)) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        // Line back high at mid-start: treat as a glitch.
                        rx_state_d = rx_in ? StIdle : StData;
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (rx_tick_q == S_W'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_in, rx_shift_q[DBIT-1:1]};
                        if (rx_bit_q == N_W'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_d = StParity;
`else
                            rx_state_d = StStop;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (rx_tick_q == S_W'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = '0;
                        rx_par_bad = (rx_in != (^rx_shift_q ^ PARITY_ODD));
                        rx_state_d = StStop;
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (rx_tick_q == S_W'(SB_TICK - 1)) begin
                        rx_state_d   = StIdle;
                        rx_done      = 1'b1;
                        rx_frame_bad = !rx_in;
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= StIdle;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // A completed byte is stored even on a framing/parity error, dropped only when full.
    assign rx_push = rx_done && !rx_full;

    uart_fifo #(
        .B(DBIT),
        .W(FIFO_W)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_push),
        .rd    (rd_uart),
        .w_data(rx_shift_q),
        .r_data(r_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- error flags ----------------
    logic frame_err_q;
    logic overrun_err_q;

    // Sticky flags; an event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= (frame_err_q & ~clr_err) | (rx_done & rx_frame_bad);
            overrun_err_q <= (overrun_err_q & ~clr_err) | (rx_done & rx_full);
        end
    end

    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

`ifdef UART_PARITY_EN
    logic parity_err_q;

    // Sticky parity flag with the same clear priority as the other flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (parity_err_q & ~clr_err) | rx_par_bad;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // ---------------- transmitter ----------------
    uart_state_e     tx_state_q, tx_state_d;
    logic [S_W-1:0]  tx_tick_q, tx_tick_d;
    logic [N_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DBIT-1:0] tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            tx_load;
    logic            tx_empty;
    logic [DBIT-1:0] tx_head;
`ifdef UART_PARITY_EN
    logic            tx_par_q, tx_par_d;
`endif

    uart_fifo #(
        .B(DBIT),
        .W(FIFO_W)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_uart),
        .rd    (tx_load),
        .w_data(w_data),
        .r_data(tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // TX next-state; the line level is derived from the next state so tx is registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        unique case (tx_state_q)
            StIdle: begin
                tx_load = !tx_empty;
            end
            StStart: begin
                if (tick) begin
                    if (tx_tick_q == S_W'(OVERSAMPLE - 1)) begin
                        tx_tick_d  = '0;
                        tx_bit_d   = '0;
                        tx_state_d = StData;
                    end else begin
                        tx_tick_d = tx_tick_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tx_tick_q == S_W'(OVERSAMPLE - 1)) begin
                        tx_tick_d  = '0;
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == N_W'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_d = StParity;
`else
                            tx_state_d = StStop;
`endif
                        end else begin
                            tx_bit_d = tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (tx_tick_q == S_W'(OVERSAMPLE - 1)) begin
                        tx_tick_d  = '0;
                        tx_state_d = StStop;
                    end else begin
                        tx_tick_d = tx_tick_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (tx_tick_q == S_W'(SB_TICK - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        tx_load    = !tx_empty;
                        tx_state_d = StIdle;
                    end else begin
                        tx_tick_d = tx_tick_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase

        if (tx_load) begin
            tx_state_d = StStart;
            tx_tick_d  = '0;
            tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head ^ PARITY_ODD;
`endif
        end

        unique case (tx_state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            StParity: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // TX state register; reset returns the line high on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx = tx_q;

endmodule
